// File: rtl/cve2_branch_predict_bht_pkg.sv
// Shared types for the fetch-stage branch predictor: opcodes, BHT counter encoding,
// decoded branch-type flags and the saturating counter steps.
package cve2_branch_predict_bht_pkg;

  localparam int unsigned InstrW = 32;
  localparam int unsigned CntW   = 2;

  typedef enum logic [6:0] {
    OPCODE_LOAD     = 7'h03,
    OPCODE_MISC_MEM = 7'h0f,
    OPCODE_OP_IMM   = 7'h13,
    OPCODE_AUIPC    = 7'h17,
    OPCODE_STORE    = 7'h23,
    OPCODE_OP       = 7'h33,
    OPCODE_LUI      = 7'h37,
    OPCODE_BRANCH   = 7'h63,
    OPCODE_JALR     = 7'h67,
    OPCODE_JAL      = 7'h6f,
    OPCODE_SYSTEM   = 7'h73
  } opcode_e;

  typedef enum logic [CntW-1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_cnt_e;

  typedef struct packed {
    logic b;
    logic j;
    logic cb;
    logic cj;
  } bp_type_t;

  function automatic bht_cnt_e bht_inc(input bht_cnt_e cnt);
    bht_cnt_e res;
    unique case (cnt)
      BHT_SNT: res = BHT_WNT;
      BHT_WNT: res = BHT_WT;
      default: res = BHT_ST;
    endcase
    return res;
  endfunction

  function automatic bht_cnt_e bht_dec(input bht_cnt_e cnt);
    bht_cnt_e res;
    unique case (cnt)
      BHT_ST:  res = BHT_WT;
      BHT_WT:  res = BHT_WNT;
      default: res = BHT_SNT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cve2_branch_predict_bht_decode.sv
// Combinational decode of fetched instruction into branch/jump type flags and the
// sign-extended target offset; B-type offset is the fallback when nothing matches.
module cve2_bp_decode
  import cve2_branch_predict_bht_pkg::*;
(
  input  logic [InstrW-1:0] i_instr,
  output bp_type_t          o_type,
  output logic [InstrW-1:0] o_imm
);

  opcode_e            w_opcode;
  logic               w_is_c;
  logic [2:0]         w_c_funct3;
  logic [InstrW-1:0]  w_imm_b;
  logic [InstrW-1:0]  w_imm_j;
  logic [InstrW-1:0]  w_imm_cb;
  logic [InstrW-1:0]  w_imm_cj;

  assign w_opcode   = opcode_e'(i_instr[6:0]);
  assign w_is_c     = (i_instr[1:0] == 2'b01);
  assign w_c_funct3 = i_instr[15:13];

  assign w_imm_b  = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_j  = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign w_imm_cb = {{23{i_instr[12]}}, i_instr[12], i_instr[6:5], i_instr[2],
                     i_instr[11:10], i_instr[4:3], 1'b0};
  assign w_imm_cj = {{20{i_instr[12]}}, i_instr[12], i_instr[8], i_instr[10:9], i_instr[6],
                     i_instr[7], i_instr[2], i_instr[11], i_instr[5:3], 1'b0};

  always_comb begin
    o_type    = '0;
    o_type.b  = (w_opcode == OPCODE_BRANCH);
    o_type.j  = (w_opcode == OPCODE_JAL);
    o_type.cb = w_is_c && ((w_c_funct3 == 3'b110) || (w_c_funct3 == 3'b111));
    o_type.cj = w_is_c && ((w_c_funct3 == 3'b101) || (w_c_funct3 == 3'b001));
  end

  always_comb begin
    o_imm = w_imm_b;
    if (o_type.j) begin
      o_imm = w_imm_j;
    end else if (o_type.cb) begin
      o_imm = w_imm_cb;
    end else if (o_type.cj) begin
      o_imm = w_imm_cj;
    end
  end

endmodule

// File: rtl/cve2_branch_predict_bht.sv
// Dynamic branch predictor: untagged table of 2-bit saturating counters trained by
// resolved branches, with a backward-taken static rule for untrained entries.
module cve2_branch_predict_bht
  import cve2_branch_predict_bht_pkg::*;
#(
  parameter int unsigned BhtEntries     = 64,
  parameter bit          StaticFallback = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [InstrW-1:0] fetch_rdata_i,
  input  logic [InstrW-1:0] fetch_pc_i,
  input  logic              fetch_valid_i,
  output logic              predict_branch_taken_o,
  output logic [InstrW-1:0] predict_branch_pc_o,
  output logic              predict_from_bht_o,
  input  logic              update_valid_i,
  input  logic [InstrW-1:0] update_pc_i,
  input  logic              update_taken_i,
  input  logic              clear_i
);

  localparam int unsigned IdxW = $clog2(BhtEntries);

  bp_type_t                w_type;
  logic [InstrW-1:0]       w_imm;
  logic [IdxW-1:0]         w_fetch_idx;
  logic [IdxW-1:0]         w_upd_idx;
  logic                    w_is_branch;
  logic                    w_is_jump;
  logic                    w_hit;
  logic [CntW-1:0]         w_hit_cnt;
  logic                    w_unused_upd_pc;

  logic [BhtEntries-1:0]   r_valid;
  bht_cnt_e                r_cnt [BhtEntries];
  logic [BhtEntries-1:0]   w_valid_nxt;
  bht_cnt_e                w_cnt_nxt [BhtEntries];

  cve2_bp_decode u_decode (
    .i_instr (fetch_rdata_i),
    .o_type  (w_type),
    .o_imm   (w_imm)
  );

  // Halfword-granular index; upper PC bits alias freely since no tags are kept.
  assign w_fetch_idx     = fetch_pc_i[IdxW:1];
  assign w_upd_idx       = update_pc_i[IdxW:1];
  assign w_unused_upd_pc = ^{update_pc_i[InstrW-1:IdxW+1], update_pc_i[0]};

  // Per-entry counter FSM: clear wins over training, untrained entries start weak.
  always_comb begin
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    if (clear_i) begin
      w_valid_nxt = '0;
    end else if (update_valid_i) begin
      if (!r_valid[w_upd_idx]) begin
        w_valid_nxt[w_upd_idx] = 1'b1;
        w_cnt_nxt[w_upd_idx]   = update_taken_i ? BHT_WT : BHT_WNT;
      end else begin
        w_cnt_nxt[w_upd_idx]   = update_taken_i ? bht_inc(r_cnt[w_upd_idx])
                                                : bht_dec(r_cnt[w_upd_idx]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= '0;
      for (int i = 0; i < int'(BhtEntries); i++) begin
        r_cnt[i] <= BHT_WNT;
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_is_branch = w_type.b | w_type.cb;
  assign w_is_jump   = w_type.j | w_type.cj;
  assign w_hit       = r_valid[w_fetch_idx];
  assign w_hit_cnt   = CntW'(r_cnt[w_fetch_idx]);

  always_comb begin
    predict_branch_taken_o = 1'b0;
    predict_from_bht_o     = 1'b0;
    if (fetch_valid_i) begin
      if (w_is_jump) begin
        predict_branch_taken_o = 1'b1;
      end else if (w_is_branch) begin
        if (w_hit) begin
          predict_branch_taken_o = w_hit_cnt[1];
          predict_from_bht_o     = 1'b1;
        end else begin
          predict_branch_taken_o = StaticFallback & w_imm[InstrW-1];
        end
      end
    end
  end

  assign predict_branch_pc_o = fetch_pc_i + w_imm;

  always_ff @(posedge clk_i) begin
    assert ((BhtEntries >= 2) && ((BhtEntries & (BhtEntries - 1)) == 0));
    if (rst_ni && fetch_valid_i) begin
      assert ($onehot0(w_type));
    end
  end

endmodule

// File: tb/tb_cve2_branch_predict_bht.sv
// Self-checking bench: directed test-plan scenarios with literal expectations, then
// randomized fetch/train/clear/reset traffic checked against a behavioural table model.
module tb_cve2_branch_predict_bht;

  localparam int ENTRIES = 64;
  localparam int K_NONE = 0, K_B = 1, K_CB = 2, K_J = 3, K_CJ = 4;

  logic        clk = 1'b0;
  logic        rst_n, fetch_valid, upd_valid, upd_taken, clr;
  logic [31:0] fetch_rdata, fetch_pc, upd_pc;
  logic        p_taken, p_fb;
  logic [31:0] p_pc;

  int total = 0;
  int bad   = 0;

  int m_valid [ENTRIES];
  int m_cnt   [ENTRIES];

  int          k_kind, k_off;
  bit          chk_on = 1'b0;
  bit          lit_en = 1'b0;
  bit          lit_taken, lit_fb;
  logic [31:0] lit_pc;

  cve2_branch_predict_bht #(.BhtEntries(ENTRIES), .StaticFallback(1'b1)) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .fetch_rdata_i          (fetch_rdata),
    .fetch_pc_i             (fetch_pc),
    .fetch_valid_i          (fetch_valid),
    .predict_branch_taken_o (p_taken),
    .predict_branch_pc_o    (p_pc),
    .predict_from_bht_o     (p_fb),
    .update_valid_i         (upd_valid),
    .update_pc_i            (upd_pc),
    .update_taken_i         (upd_taken),
    .clear_i                (clr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int kind, input int off);
    logic [20:0] o;
    logic [15:0] c;
    logic [31:0] r;
    o = 21'(off);
    r = $urandom;
    case (kind)
      K_B:    r = {o[12], o[10:5], r[24:20], r[19:15], r[14:12], o[4:1], o[11], 7'h63};
      K_NONE: r = {o[12], o[10:5], r[24:20], r[19:15], r[14:12], o[4:1], o[11], 7'h33};
      K_J:    r = {o[20], o[10:1], o[11], o[19:12], r[11:7], 7'h6f};
      K_CB: begin
        c = {2'b11, r[0], o[8], o[4:3], r[3:1], o[7:6], o[2:1], o[5], 2'b01};
        r = {r[31:16], c};
      end
      default: begin
        c = {r[0] ? 3'b101 : 3'b001, o[11], o[4], o[9:8], o[10], o[6], o[7], o[3:1], o[5], 2'b01};
        r = {r[31:16], c};
      end
    endcase
    return r;
  endfunction

  function automatic int rand_off(input int kind);
    case (kind)
      K_CB:    return int'($urandom_range(0, 255)) * 2 - 256;
      K_J:     return int'($urandom_range(0, 1048575)) * 2 - 1048576;
      K_CJ:    return int'($urandom_range(0, 2047)) * 2 - 2048;
      default: return int'($urandom_range(0, 4095)) * 2 - 4096;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Table model: trained on the rising edge exactly as the rules describe.
  always @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    end else if (upd_valid) begin
      int ix;
      ix = int'((upd_pc >> 1) % 32'(ENTRIES));
      if (m_valid[ix] == 0) begin
        m_valid[ix] = 1;
        m_cnt[ix]   = upd_taken ? 2 : 1;
      end else if (upd_taken) begin
        m_cnt[ix] = (m_cnt[ix] == 3) ? 3 : m_cnt[ix] + 1;
      end else begin
        m_cnt[ix] = (m_cnt[ix] == 0) ? 0 : m_cnt[ix] - 1;
      end
    end
  end

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      int          ix;
      bit          e_t, e_fb;
      logic [31:0] e_pc;
      ix   = int'((fetch_pc >> 1) % 32'(ENTRIES));
      e_pc = fetch_pc + 32'(k_off);
      e_t  = 1'b0;
      e_fb = 1'b0;
      if (fetch_valid) begin
        if (k_kind == K_J || k_kind == K_CJ) begin
          e_t = 1'b1;
        end else if (k_kind == K_B || k_kind == K_CB) begin
          if (m_valid[ix] != 0) begin
            e_t  = (m_cnt[ix] >= 2);
            e_fb = 1'b1;
          end else begin
            e_t = (k_off < 0);
          end
        end
      end
      cmp("taken", 32'(p_taken), 32'(e_t));
      cmp("target", p_pc, e_pc);
      cmp("from_bht", 32'(p_fb), 32'(e_fb));
      if (lit_en) begin
        cmp("lit_taken", 32'(p_taken), 32'(lit_taken));
        cmp("lit_target", p_pc, lit_pc);
        cmp("lit_from_bht", 32'(p_fb), 32'(lit_fb));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int kind, input int off, input logic [31:0] pc);
    k_kind      = kind;
    k_off       = off;
    fetch_rdata = mk(kind, off);
    fetch_pc    = pc;
    fetch_valid = 1'b1;
  endtask

  task automatic lit(input bit t, input logic [31:0] pc, input bit fb);
    lit_en    = 1'b1;
    lit_taken = t;
    lit_pc    = pc;
    lit_fb    = fb;
  endtask

  task automatic upd(input logic [31:0] pc, input bit t);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = t;
  endtask

  task automatic quiet();
    lit_en      = 1'b0;
    upd_valid   = 1'b0;
    clr         = 1'b0;
    fetch_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    fetch(K_NONE, 0, 32'h40);
    fetch_valid = 1'b0;
    upd(32'h100, 1'b1);
    cyc();
    chk_on = 1'b1;
    lit(1'b0, 32'h40, 1'b0);
    cyc();
    cyc();

    // Static fallback right after reset; the update held during reset was dropped.
    rst_n = 1'b1;
    quiet();
    fetch(K_B, -8, 32'h100); lit(1'b1, 32'hF8, 1'b0); cyc();
    fetch(K_B, 8, 32'h100);  lit(1'b0, 32'h108, 1'b0); cyc();

    // Same-cycle collision sees the old (untrained) entry.
    fetch(K_B, -8, 32'h100); lit(1'b1, 32'hF8, 1'b0); upd(32'h100, 1'b0); cyc();
    quiet();
    fetch(K_B, -8, 32'h100); lit(1'b0, 32'hF8, 1'b1); cyc();

    quiet();
    for (int i = 0; i < 3; i++) begin upd(32'h100, 1'b1); cyc(); end
    quiet();
    upd(32'h100, 1'b0); cyc();
    quiet();
    fetch(K_B, -8, 32'h100); lit(1'b1, 32'hF8, 1'b1); cyc();
    fetch(K_B, -8, 32'h180); lit(1'b1, 32'h178, 1'b1); cyc();

    quiet();
    for (int i = 0; i < 4; i++) begin upd(32'h100, 1'b0); cyc(); end
    quiet();
    fetch(K_B, 8, 32'h100); lit(1'b0, 32'h108, 1'b1); cyc();
    quiet();
    upd(32'h100, 1'b1); cyc();
    quiet();
    fetch(K_B, -8, 32'h100);  lit(1'b0, 32'hF8, 1'b1); cyc();
    fetch(K_CB, -8, 32'h100); lit(1'b0, 32'hF8, 1'b1); cyc();

    fetch(K_CJ, -4, 32'h200);     lit(1'b1, 32'h1FC, 1'b0); cyc();
    fetch(K_J, 32'h800, 32'h200); lit(1'b1, 32'hA00, 1'b0); cyc();

    // Clear beats a simultaneous update.
    quiet();
    clr = 1'b1; upd(32'h100, 1'b1); cyc();
    quiet();
    fetch(K_B, 8, 32'h100); lit(1'b0, 32'h108, 1'b0); cyc();
    quiet();
    upd(32'h100, 1'b1); cyc();
    quiet();
    fetch(K_B, 8, 32'h100); lit(1'b1, 32'h108, 1'b1); cyc();
    quiet();
    rst_n = 1'b0; upd(32'h100, 1'b1); cyc();
    rst_n = 1'b1;
    quiet();
    fetch(K_B, 8, 32'h100); lit(1'b0, 32'h108, 1'b0); cyc();
    quiet();

    for (int n = 0; n < 4000; n++) begin
      int kind;
      rst_n     = ($urandom_range(0, 299) != 0);
      clr       = ($urandom_range(0, 99) == 0);
      upd_valid = $urandom_range(0, 1) == 1;
      upd_pc    = 32'h100 + 32'(2 * $urandom_range(0, 127));
      upd_taken = ($urandom_range(0, 3) != 0);
      kind      = int'($urandom_range(0, 4));
      fetch(kind, rand_off(kind), 32'h100 + 32'(2 * $urandom_range(0, 127)));
      if ($urandom_range(0, 3) == 0) fetch_pc = upd_pc;
      if ($urandom_range(0, 7) == 0) fetch_pc = $urandom;
      fetch_valid = ($urandom_range(0, 4) != 0);
      cyc();
    end

    quiet();
    rst_n = 1'b1;
    cyc();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
